// File: rtl/comb_line_rmw.sv
// Read-modify-write engine for the wide-line audio delay buffer: merges one sample into its
// memory line (replace or saturating accumulate) with a one-line write-through cache.
module comb_line_rmw #(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int WORDS_PER_LINE = 64,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 2,
    localparam int LW     = SAMPLE_WIDTH * WORDS_PER_LINE,
    localparam int SLOT_W = $clog2(WORDS_PER_LINE),
    localparam int IW     = ADDR_WIDTH + SLOT_W
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    input  logic [SAMPLE_WIDTH-1:0] audio_in,
    input  logic [IW-1:0]           audio_buffer_index_in,
    input  logic                    mode_in,
    input  logic                    invalidate_in,
    output logic [ADDR_WIDTH-1:0]   mem_addr_out,
    output logic                    mem_re_out,
    input  logic [LW-1:0]           mem_rdata_in,
    output logic                    mem_we_out,
    output logic [LW-1:0]           mem_wdata_out,
    output logic                    done_out
);

    // state  | meaning
    // IDLE   | ready for a sample; hit goes straight to WRITE
    // READ   | one-cycle read strobe for the target line
    // WAIT   | read latency countdown; line captured on the last cycle
    // WRITE  | merged line written back and cached, done pulse
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_WRITE} state_t;

    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [SAMPLE_WIDTH-1:0] SAT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic [SAMPLE_WIDTH-1:0] SAT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    state_t state, state_nx;

    logic [SAMPLE_WIDTH-1:0] sample_q;
    logic [SLOT_W-1:0]       slot_q;
    logic [ADDR_WIDTH-1:0]   line_addr_q;
    logic                    mode_q;
    logic [LW-1:0]           base_q;
    logic [CNT_W-1:0]        wait_cnt;

    logic                    cache_valid;
    logic [ADDR_WIDTH-1:0]   cache_addr;
    logic [LW-1:0]           cache_line;

    logic [ADDR_WIDTH-1:0]   idx_line;
    logic [SLOT_W-1:0]       idx_slot;
    logic                    hit;
    logic                    accept;

    int unsigned             bit_ofs;
    logic [SAMPLE_WIDTH-1:0] old_word;
    logic [SAMPLE_WIDTH:0]   sum;
    logic [SAMPLE_WIDTH-1:0] sat_word;
    logic [SAMPLE_WIDTH-1:0] new_word;
    logic [LW-1:0]           merged;

    assign idx_line = audio_buffer_index_in[IW-1:SLOT_W];
    assign idx_slot = audio_buffer_index_in[SLOT_W-1:0];
    // An invalidate in the accept cycle forces the read path even on an address match.
    assign hit      = cache_valid && (cache_addr == idx_line) && !invalidate_in;
    assign accept   = (state == S_IDLE) && sample_valid_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        sample_ready_out = 1'b0;
        mem_re_out       = 1'b0;
        mem_we_out       = 1'b0;
        case (state)
            S_IDLE: begin
                sample_ready_out = 1'b1;
                if (sample_valid_in) begin
                    state_nx = hit ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                mem_re_out = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we_out = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bit_ofs  = 32'(slot_q) * SAMPLE_WIDTH;
        old_word = base_q[bit_ofs +: SAMPLE_WIDTH];
        sum      = {old_word[SAMPLE_WIDTH-1], old_word} + {sample_q[SAMPLE_WIDTH-1], sample_q};
        sat_word = sum[SAMPLE_WIDTH-1:0];
        if (sum[SAMPLE_WIDTH] != sum[SAMPLE_WIDTH-1]) begin
            sat_word = sum[SAMPLE_WIDTH] ? SAT_MIN : SAT_MAX;
        end
        new_word = mode_q ? sat_word : sample_q;
        merged   = base_q;
        merged[bit_ofs +: SAMPLE_WIDTH] = new_word;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_q    <= '0;
            slot_q      <= '0;
            line_addr_q <= '0;
            mode_q      <= 1'b0;
            base_q      <= '0;
            wait_cnt    <= '0;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_line  <= '0;
        end else begin
            if (accept) begin
                sample_q    <= audio_in;
                slot_q      <= idx_slot;
                line_addr_q <= idx_line;
                mode_q      <= mode_in;
                base_q      <= cache_line;
            end
            if (state == S_READ) begin
                wait_cnt <= CNT_W'(READ_LATENCY - 1);
            end
            if (state == S_WAIT) begin
                if (wait_cnt == '0) begin
                    base_q <= mem_rdata_in;
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
            // Invalidate during the write cycle wins over caching the fresh line.
            if (state == S_WRITE) begin
                cache_line  <= merged;
                cache_addr  <= line_addr_q;
                cache_valid <= !invalidate_in;
            end else if (invalidate_in) begin
                cache_valid <= 1'b0;
            end
        end
    end

    assign mem_addr_out  = line_addr_q;
    assign mem_wdata_out = mem_we_out ? merged : '0;
    assign done_out      = mem_we_out;

endmodule

// File: tb/tb_comb_line_rmw.sv
// Scoreboard bench for comb_line_rmw: a line-memory responder, a reference merge model and
// two extra instances at other read latencies driven with a held-high valid.
module tb_comb_line_rmw;

    localparam int SW  = 16;
    localparam int W   = 64;
    localparam int AW  = 10;
    localparam int L   = 2;
    localparam int LW  = SW * W;
    localparam int SLW = $clog2(W);
    localparam int IW  = AW + SLW;

    typedef struct {
        int            re_cyc;
        int            we_cyc;
        logic          miss;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          sample_valid;
    logic          sample_ready;
    logic [SW-1:0] audio;
    logic [IW-1:0] index;
    logic          mode;
    logic          invalidate;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [LW-1:0] mem_rdata;
    logic          mem_we;
    logic [LW-1:0] mem_wdata;
    logic          done;

    logic [LW-1:0] mem       [1<<AW];
    logic [LW-1:0] model_mem [1<<AW];
    logic [LW-1:0] rd_pipe   [L];

    exp_t          sb[$];
    exp_t          mon_e;
    logic          tb_cv;
    logic [AW-1:0] tb_ca;
    int            cyc;
    int            n_vec;
    int            n_err;

    logic          hv_valid;
    logic [IW-1:0] hv_idx;
    logic [SW-1:0] hv_audio;
    logic [LW-1:0] zero_line;

    comb_line_rmw #(
        .SAMPLE_WIDTH(SW), .WORDS_PER_LINE(W), .ADDR_WIDTH(AW), .READ_LATENCY(L)
    ) u_dut (
        .clk_in(clk),
        .rst_in(rst),
        .sample_valid_in(sample_valid),
        .sample_ready_out(sample_ready),
        .audio_in(audio),
        .audio_buffer_index_in(index),
        .mode_in(mode),
        .invalidate_in(invalidate),
        .mem_addr_out(mem_addr),
        .mem_re_out(mem_re),
        .mem_rdata_in(mem_rdata),
        .mem_we_out(mem_we),
        .mem_wdata_out(mem_wdata),
        .done_out(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line memory: out-of-window cycles return all ones so a mistimed capture shows up.
    assign mem_rdata = rd_pipe[L-1];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_re ? mem[mem_addr] : '1;
        for (int k = 1; k < L; k++) rd_pipe[k] <= rd_pipe[k-1];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    function automatic logic [LW-1:0] model_merge(input logic [LW-1:0] line, input int slot,
                                                  input logic [SW-1:0] a, input logic md);
        int old_v, new_v, hi, lo;
        hi    = (1 << (SW - 1)) - 1;
        lo    = -(1 << (SW - 1));
        old_v = $signed(line[slot*SW +: SW]);
        new_v = md ? old_v + $signed(a) : $signed(a);
        if (new_v > hi) new_v = hi;
        if (new_v < lo) new_v = lo;
        line[slot*SW +: SW] = new_v[SW-1:0];
        return line;
    endfunction

    always @(negedge clk) begin
        if (mem_re) begin
            if (sb.size() == 0 || !sb[0].miss) begin
                chk("spurious_re", 1, 0);
            end else begin
                chk("re_cycle", cyc, sb[0].re_cyc);
                chk("re_addr", mem_addr, sb[0].addr);
            end
        end
        if (done && !mem_we) chk("stray_done", 1, 0);
        if (mem_we) begin
            chk("ready_in_write", sample_ready, 0);
            if (sb.size() == 0) begin
                chk("spurious_we", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("we_cycle", cyc, mon_e.we_cyc);
                chk("we_addr", mem_addr, mon_e.addr);
                chk("done_with_we", done, 1);
                for (int w = 0; w < W; w++)
                    chk($sformatf("wdata[%0d]", w), mem_wdata[w*SW +: SW], mon_e.line[w*SW +: SW]);
            end
        end
    end

    // inv_mode: 0 none, 1 invalidate in the accept cycle, 2 invalidate in the following cycle
    task automatic send(input logic [IW-1:0] idx, input logic [SW-1:0] a, input logic md,
                        input int inv_mode);
        exp_t          e;
        logic [AW-1:0] ln;
        int            sl;
        logic          hit;
        int            n;
        n = 0;
        while (!sample_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        ln       = idx[IW-1:SLW];
        sl       = int'(idx[SLW-1:0]);
        hit      = tb_cv && (tb_ca == ln) && (inv_mode != 1);
        e.miss   = !hit;
        e.re_cyc = cyc + 1;
        e.we_cyc = hit ? cyc + 1 : cyc + 2 + L;
        e.addr   = ln;
        e.line   = model_merge(model_mem[ln], sl, a, md);
        model_mem[ln] = e.line;
        tb_cv = 1'b1;
        tb_ca = ln;
        sb.push_back(e);
        sample_valid = 1'b1;
        index        = idx;
        audio        = a;
        mode         = md;
        invalidate   = (inv_mode == 1);
        @(negedge clk);
        sample_valid = 1'b0;
        audio        = SW'($urandom);
        index        = IW'($urandom);
        mode         = 1'($urandom);
        invalidate   = (inv_mode == 2);
        if (inv_mode == 2 && hit) tb_cv = 1'b0;
        if (inv_mode == 2) begin
            @(negedge clk);
            invalidate = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic pulse_inv();
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        tb_cv = 1'b0;
    endtask

    task automatic set_word(input int ln, input int slot, input logic [SW-1:0] v);
        logic [LW-1:0] t;
        t = mem[ln];
        t[slot*SW +: SW] = v;
        mem[ln]       = t;
        model_mem[ln] = t;
    endtask

    function automatic logic [SW-1:0] mem_word(input int ln, input int slot);
        logic [LW-1:0] t;
        t = mem[ln];
        return t[slot*SW +: SW];
    endfunction

    // Two more instances at latencies 1 and 4, fed by a held-high valid with a new line every cycle.
    assign zero_line = '0;
    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int GL = (gi == 0) ? 1 : 4;
        logic          rdy, re, we, dn;
        logic [AW-1:0] ad;
        logic [LW-1:0] wd;
        int            acc_cnt  = 0;
        int            wr_cnt   = 0;
        int            last_acc = -1;
        int            exp_q[$];

        comb_line_rmw #(
            .SAMPLE_WIDTH(SW), .WORDS_PER_LINE(W), .ADDR_WIDTH(AW), .READ_LATENCY(GL)
        ) u_hold (
            .clk_in(clk),
            .rst_in(rst),
            .sample_valid_in(hv_valid),
            .sample_ready_out(rdy),
            .audio_in(hv_audio),
            .audio_buffer_index_in(hv_idx),
            .mode_in(1'b0),
            .invalidate_in(1'b0),
            .mem_addr_out(ad),
            .mem_re_out(re),
            .mem_rdata_in(zero_line),
            .mem_we_out(we),
            .mem_wdata_out(wd),
            .done_out(dn)
        );

        always @(negedge clk) begin
            if (!rst) begin
                if (exp_q.size() != 0) chk($sformatf("hold_l%0d_ready_busy", GL), rdy, 0);
                if (we) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) chk($sformatf("hold_l%0d_spurious_we", GL), 1, 0);
                    else chk($sformatf("hold_l%0d_we_cycle", GL), cyc, exp_q.pop_front());
                end
                if (hv_valid && rdy) begin
                    if (last_acc >= 0) chk($sformatf("hold_l%0d_spacing", GL), cyc - last_acc, 3 + GL);
                    last_acc = cyc;
                    acc_cnt++;
                    exp_q.push_back(cyc + 2 + GL);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0] saved;
        logic [SW-1:0] a;
        int            ln, sl;
        cyc = 0; n_vec = 0; n_err = 0;
        rst = 1'b1; sample_valid = 1'b0; audio = '0; index = '0; mode = 1'b0; invalidate = 1'b0;
        hv_valid = 1'b0; hv_idx = '0; hv_audio = 16'h0001;
        tb_cv = 1'b0; tb_ca = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]       = {W{16'hAAAA}};
            model_mem[i] = {W{16'hAAAA}};
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", sample_ready, 1);
        chk("rst_re", mem_re, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata_zero", mem_wdata == '0, 1);
        rst = 1'b0;
        @(negedge clk);

        // replace into a fresh line, then a same-line hit
        send(16'h0005, 16'h1234, 1'b0, 0);
        drain();
        chk("t1_word5", mem_word(0, 5), 16'h1234);
        chk("t1_word4", mem_word(0, 4), 16'hAAAA);
        send(16'h003F, 16'h0BEE, 1'b0, 0);
        drain();
        chk("t2_word63", mem_word(0, 63), 16'h0BEE);
        chk("t2_word5", mem_word(0, 5), 16'h1234);

        // saturation at both rails; second op replays on a miss after an external write
        set_word(1, 1, 16'h7FF0);
        send(16'h0041, 16'h0100, 1'b1, 0);
        drain();
        chk("t3_sat_pos", mem_word(1, 1), 16'h7FFF);
        set_word(1, 1, 16'h8010);
        pulse_inv();
        send(16'h0041, 16'hFF00, 1'b1, 0);
        drain();
        chk("t3_sat_neg", mem_word(1, 1), 16'h8000);

        // invalidate between same-line samples, in the accept cycle, and in the write cycle
        send(16'h0080, 16'h1111, 1'b0, 0);
        send(16'h0083, 16'h2222, 1'b0, 0);
        drain();
        pulse_inv();
        send(16'h0085, 16'h3333, 1'b0, 0);
        send(16'h0086, 16'h4444, 1'b0, 1);
        send(16'h0087, 16'h5555, 1'b1, 2);
        send(16'h0088, 16'h6666, 1'b0, 0);
        drain();

        // reset in WAIT abandons the op; the next same-line sample misses
        saved = model_mem[3];
        send(16'h00C2, 16'h4444, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_mem[3] = saved;
        tb_cv = 1'b0;
        chk("t5_ready_after_rst", sample_ready, 1);
        chk("t5_no_we", mem_we, 0);
        repeat (3) @(negedge clk);
        chk("t5_line_untouched", mem[3] == saved, 1);
        send(16'h00C7, 16'h0777, 1'b0, 0);
        drain();

        // mixed traffic over a few lines with rail values and slot edges
        for (int i = 0; i < 40; i++) begin
            ln = $urandom_range(0, 3);
            sl = (i % 5 == 0) ? 0 : (i % 5 == 1) ? W - 1 : $urandom_range(0, W - 1);
            case ($urandom_range(0, 3))
                0: a = 16'h7FFF;
                1: a = 16'h8000;
                default: a = SW'($urandom);
            endcase
            send(IW'((ln << SLW) | sl), a, 1'($urandom), ($urandom_range(0, 5) == 0) ? 1 : 0);
            if ($urandom_range(0, 7) == 0) begin
                drain();
                pulse_inv();
            end
        end
        drain();

        // held valid into the latency-1 and latency-4 instances
        @(posedge clk);
        #1;
        hv_valid = 1'b1;
        repeat (20) begin
            hv_idx = {AW'(cyc), SLW'(3)};
            @(posedge clk);
            #1;
        end
        hv_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("hold_l1_accepts", g[0].acc_cnt, 5);
        chk("hold_l1_writes", g[0].wr_cnt, 5);
        chk("hold_l4_accepts", g[1].acc_cnt, 3);
        chk("hold_l4_writes", g[1].wr_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
